// File: rtl/math_pkg.sv
// math_pkg: shared types and defaults for the iterative arithmetic units
package math_pkg;
    localparam int DIV_W = 64;
    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-compare-subtract iteration of the divider
module div_step
    import math_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);
    logic [WIDTH:0] sh;
    logic           ge;
    // the shifted remainder needs one extra bit since |divisor| may exceed 2^(WIDTH-1)
    assign sh       = {rem, quo[WIDTH-1]};
    assign ge       = sh >= {1'b0, divisor};
    assign next_rem = ge ? sh[WIDTH-1:0] - divisor : sh[WIDTH-1:0];
    assign next_quo = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/div_seq.sv
// div_seq: fixed-latency radix-2 restoring divider, signed or unsigned
module div_seq
    import math_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             doSigned,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       state, state_nx;
    logic [WIDTH-1:0] dvd, dvs, rem, quo, next_rem, next_quo;
    logic             sgn, neg_q, neg_r;
    logic [CW-1:0]    cnt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .next_rem (next_rem),
        .next_quo (next_quo)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nx = state;
        busy     = state != IDLE;
        done     = state == DONE;
        unique case (state)
            IDLE:    state_nx = start ? PREP : IDLE;
            PREP:    state_nx = RUN;
            RUN:     state_nx = (cnt == CW'(WIDTH - 1)) ? FIX : RUN;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // operand capture, iteration datapath and result registers; dvd keeps the raw dividend for div-by-zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            sgn         <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    dvd   <= dividend;
                    dvs   <= divisor;
                    sgn   <= doSigned;
                    neg_q <= doSigned & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r <= doSigned & dividend[WIDTH-1];
                end
                PREP: begin
                    quo <= (sgn && dvd[WIDTH-1]) ? -dvd : dvd;
                    dvs <= (sgn && dvs[WIDTH-1]) ? -dvs : dvs;
                    rem <= '0;
                    cnt <= '0;
                end
                RUN: begin
                    rem <= next_rem;
                    quo <= next_quo;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    quotient    <= (dvs == '0) ? '0  : neg_q ? -quo : quo;
                    remainder   <= (dvs == '0) ? dvd : neg_r ? -rem : rem;
                    div_by_zero <= dvs == '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative 64-bit integer divider. It is the inverse companion of the mult unit and implements the UDIV/SDIV instructions.
- Radix-2 restoring algorithm: one quotient bit per clock, fixed latency.
- Start/busy/done handshake to the datapath control. Produces quotient and remainder, signed or unsigned, selected by doSigned.

Parameters:
- WIDTH, 64, operand/result width in bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request. Sampled only in IDLE.
- dividend  input  WIDTH  numerator. Captured on the accepting edge.
- divisor  input  WIDTH  denominator. Captured on the accepting edge.
- doSigned  input  1  1: signed (two's complement), 0: unsigned. Captured with the operands.
- busy  output  1  high from the accepting edge until done deasserts
- done  output  1  one-cycle pulse: results valid
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_by_zero  output  1  registered flag, updated together with the results

Behaviour:
- One clock domain, clk. reset is asynchronous, active-high.
- On reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; iteration counter=0.
- Reset mid-operation aborts immediately. No done is produced and outputs return to 0.

States:
- IDLE: busy=0. On an edge with start=1:
  - capture operands and doSigned;
  - record neg_q = doSigned & (dividend[MSB] ^ divisor[MSB]);
  - record neg_r = doSigned & dividend[MSB];
  - go to PREP.
- PREP: if doSigned, replace each operand with its magnitude (two's-complement negate when MSB=1; the most-negative value stays as-is and is treated as unsigned 2^(WIDTH-1)). Clear partial remainder. Counter=0. Go to RUN.
- RUN: each cycle:
  - shift {rem, quo} left by 1, bringing in the dividend MSB;
  - if rem >= |divisor|, subtract it and set the quotient LSB to 1.
  - Runs for WIDTH cycles (counter 0..WIDTH-1). After the last cycle, go to FIX.
- FIX:
  - apply sign corrections: negate quo if neg_q; negate rem if neg_r;
  - if divisor==0, override: quotient=0, remainder=original dividend, div_by_zero=1;
  - otherwise div_by_zero=0;
  - register the outputs and go to DONE.
- DONE: done=1 for exactly one cycle, busy=1. Next edge returns to IDLE.

Latency:
- Accepting edge E0. done is high in the cycle following edge E0+WIDTH+2 (E66 for WIDTH=64), i.e. WIDTH+3 edges after acceptance.
- Latency is fixed and independent of operand values, including divide by zero.
- A new start may be accepted on the edge that leaves DONE? No: the DONE→IDLE edge does not sample start. The earliest re-accept is one edge later.

Handshake and outputs:
- start while busy=1 is ignored entirely; captured operands are unaffected.
- Operand inputs may change freely after acceptance.
- quotient/remainder/div_by_zero hold their value from DONE until the next FIX (or reset).

Arithmetic rules:
- Quotient truncates toward zero.
- Remainder takes the sign of the dividend.
- dividend = quotient*divisor + remainder holds modulo 2^WIDTH for every non-zero divisor.
- Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0, div_by_zero = 0.
- Unsigned mode ignores MSBs for sign purposes.

Decomposition:
- Shared package math_pkg:
  - typedef enum logic [2:0] div_state_t {IDLE, PREP, RUN, FIX, DONE};
  - localparam DIV_W = 64 (default for WIDTH).
- Sub-module div_step (combinational, WIDTH-parameterised):
  - inputs: rem, quo, divisor;
  - outputs: next_rem, next_quo, i.e. one shift-compare-subtract iteration.
- The top level holds the FSM, counter, sign flags and output registers.

Test Plan:
- Unsigned 100 / 7, doSigned=0 -> quotient=14, remainder=2, div_by_zero=0. done exactly 67 clocks after the accepting edge, busy high throughout.
- Signed -100 / 7, doSigned=1 -> quotient=0xFFFFFFFFFFFFFFF2 (-14), remainder=0xFFFFFFFFFFFFFFFE (-2). Repeat with 100 / -7 -> quotient=-14, remainder=2.
- Divide by zero, dividend=0xDEADBEEFDECAFBAD, divisor=0, both modes -> quotient=0, remainder=0xDEADBEEFDECAFBAD, div_by_zero=1, done still at 67 clocks.
- Signed overflow 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> quotient=0x8000000000000000, remainder=0. Same operands unsigned -> quotient=0, remainder=0x8000000000000000.
- Busy and reset behaviour:
  - Accept 0xFFFFFFFFFFFFFFFF / 3 unsigned.
  - Pulse start with 10/2 at clock 20 -> ignored; result is quotient=0x5555555555555555, remainder=0.
  - Next run: assert reset at clock 30 -> busy=0, all outputs 0, no done pulse.
  - A fresh 9/4 then yields quotient=2, remainder=1.
- Random self-check: 1000 random operand pairs in each mode, compared against the language / and % operators (with the zero and overflow rules above), back-to-back starts at minimum spacing.
